// File: rtl/spi_wb_pkg.sv
// Shared encodings for the SPI-to-Wishbone bridge: FSM states, command layout, timeout data.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    RD_WAIT,
    RDATA,
    WDATA,
    WR_REQ,
    WR_WAIT
  } state_t;

  // Command byte: bit 7 selects write, low bits carry the start address.
  localparam int CMD_WR_BIT = 7;

  // Data returned to the host when a read gets no ack in time.
  localparam logic [7:0] TIMEOUT_RD_VAL = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input, plus rise/fall pulses on the synced level.
// Latency: level valid 2 cycles after the input settles; rise/fall pulse in that same cycle.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
module spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  // Resynchronise din and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/spi_wb_master.sv
// Bridges an SPI-slave command stream onto single Wishbone classic read/write cycles.
// Latency: 4 clocks from the last rising SCK of a byte to stb (2 sync, 1 edge detect, 1 FSM).
// Backpressure: none toward SPI; slave stalls are bounded by TIMEOUT and SCK <= clk/8 avoids overrun.
module spi_wb_master
  import spi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  wb_clk_in,
  input  logic                  wb_rst_in,
  input  logic                  spi_sck_in,
  input  logic                  spi_cs_n_in,
  input  logic                  spi_mosi_in,
  output logic                  spi_miso_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [WIDTH-1:0]      wb_dat_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_in,
  input  logic [WIDTH-1:0]      wb_dat_in,
  output logic                  busy_o,
  output logic                  err_o
);

  if (WIDTH != 8) begin : g_width_chk
    $error("spi_wb_master: WIDTH must be 8");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 7) begin : g_addr_chk
    $error("spi_wb_master: ADDR_WIDTH must be 1..7");
  end
  if (TIMEOUT < 2) begin : g_tmo_chk
    $error("spi_wb_master: TIMEOUT must be at least 2");
  end

  localparam int TW = $clog2(TIMEOUT);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync u_sync_sck  (.clk(wb_clk_in), .rst(wb_rst_in), .din(spi_sck_in),
                        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_sync u_sync_cs   (.clk(wb_clk_in), .rst(wb_rst_in), .din(spi_cs_n_in),
                        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync u_sync_mosi (.clk(wb_clk_in), .rst(wb_rst_in), .din(spi_mosi_in),
                        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  logic sync_unused;
  assign sync_unused = ^{sck_lvl, cs_rise, mosi_rise, mosi_fall};

  state_t                state, nxt;
  logic [2:0]            bitcnt;
  logic [WIDTH-2:0]      rx_sh;
  logic [WIDTH-1:0]      rx_byte;
  logic                  byte_pend;
  logic [WIDTH-1:0]      tx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdat;
  logic [WIDTH-1:0]      prefetch;
  logic [TW-1:0]         tcnt;
  logic                  err;

  // A completed byte is taken only in the shifting states and never once CS has gone high.
  logic consume, tmo, wb_done;
  assign consume = byte_pend && !cs_lvl && (state == CMD || state == WDATA || state == RDATA);
  assign tmo     = (tcnt == TW'(TIMEOUT - 1));
  assign wb_done = wb_ack_in || tmo;

  // FSM state register.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) state <= IDLE;
    else           state <= nxt;
  end

  // Next state; an in-flight Wishbone cycle always runs to ack/timeout before returning to IDLE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cs_fall) nxt = CMD;
      CMD:     if (cs_lvl) nxt = IDLE;
               else if (byte_pend) nxt = rx_byte[CMD_WR_BIT] ? WDATA : RD_REQ;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: if (wb_done) nxt = cs_lvl ? IDLE : RDATA;
      RDATA:   if (cs_lvl) nxt = IDLE;
               else if (byte_pend) nxt = RD_REQ;
      WDATA:   if (cs_lvl) nxt = IDLE;
               else if (byte_pend) nxt = WR_REQ;
      WR_REQ:  nxt = WR_WAIT;
      WR_WAIT: if (wb_done) nxt = cs_lvl ? IDLE : WDATA;
      default: nxt = IDLE;
    endcase
  end

  // SPI shifters: sample MOSI on rising SCK, advance MISO on falling SCK except right after a
  // byte boundary, where the freshly loaded MSB must stay on the wire for the next first bit.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      bitcnt    <= '0;
      rx_sh     <= '0;
      rx_byte   <= '0;
      byte_pend <= 1'b0;
      tx        <= '0;
    end else if (cs_lvl) begin
      bitcnt    <= '0;
      byte_pend <= 1'b0;
      tx        <= '0;
    end else begin
      if (consume) byte_pend <= 1'b0;
      if (state == RDATA && consume) tx <= prefetch;
      else if (sck_fall && bitcnt != 3'd0) tx <= {tx[WIDTH-2:0], 1'b0};
      if (sck_rise) begin
        if (bitcnt == 3'd7) begin
          rx_byte   <= {rx_sh, mosi_lvl};
          byte_pend <= 1'b1;
        end else begin
          rx_sh <= {rx_sh[WIDTH-3:0], mosi_lvl};
        end
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

  // Wishbone datapath: address counter, write data, read prefetch, timeout counter, error flag.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      addr     <= '0;
      wdat     <= '0;
      prefetch <= '0;
      tcnt     <= '0;
      err      <= 1'b0;
    end else begin
      if (state == CMD && consume)   addr <= rx_byte[ADDR_WIDTH-1:0];
      if (state == RDATA && consume) addr <= addr + 1'b1;
      if (state == WDATA && consume) wdat <= rx_byte;
      if (state == WR_WAIT && wb_done) addr <= addr + 1'b1;
      if (state == RD_WAIT && wb_done) prefetch <= wb_ack_in ? wb_dat_in : TIMEOUT_RD_VAL;
      // REQ is the first cycle of cyc, so the count starts at 1 entering WAIT.
      if (state == RD_REQ || state == WR_REQ)        tcnt <= TW'(1);
      else if (state == RD_WAIT || state == WR_WAIT) tcnt <= tcnt + 1'b1;
      if (state == IDLE && cs_fall) err <= 1'b0;
      else if ((state == RD_WAIT || state == WR_WAIT) && !wb_ack_in && tmo) err <= 1'b1;
    end
  end

  assign wb_cyc_o   = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ) || (state == WR_WAIT);
  assign wb_stb_o   = wb_cyc_o;
  assign wb_we_o    = (state == WR_REQ) || (state == WR_WAIT);
  assign wb_adr_o   = wb_cyc_o ? addr : '0;
  assign wb_dat_o   = wb_we_o ? wdat : '0;
  assign busy_o     = (state != IDLE);
  assign err_o      = err;
  assign spi_miso_o = tx[WIDTH-1];

endmodule
